// File: rtl/noc_inject.sv
// noc_inject: network-interface injector feeding a mesh router local port.
// Serialises a packet request plus a payload word stream into head/body/tail
// flits on a single virtual channel. A flit is issued only when the router
// reports space on that VC.
// Optional feature: define NOC_INJECT_VC_RR_EN to pick the VC round-robin per
// packet. Without it, every packet rides VC 0.
module noc_inject #(
    parameter int DATA_W     = 64,
    parameter int VCH_N      = 2,
    parameter int VCHW       = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    input  logic [3:0]        req_dst_x,
    input  logic [3:0]        req_dst_y,
    output logic              req_ready,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W+1:0] odata,
    output logic              ovalid,
    output logic [VCHW-1:0]   ovch,
    input  logic [VCH_N-1:0]  ordy,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic [1:0]        state;
    logic [3:0]        dst_x_q;
    logic [3:0]        dst_y_q;
    logic [VCHW-1:0]   vc_q;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              req_fire;
    logic              vc_rdy;
    logic [DATA_W-1:0] head_payload;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_head  = mem[rd_ptr];

    // Handshake outputs are held low while reset is asserted.
    assign s_ready   = rst_ && !fifo_full;
    assign req_ready = rst_ && (state == ST_IDLE);
    assign busy      = rst_ && (state != ST_IDLE);
    assign push      = s_valid && s_ready;
    assign req_fire  = req_valid && req_ready;
    assign vc_rdy    = ordy[vc_q];
    assign pop       = ovalid && (state == ST_BODY);

    // Flit assembly and issue: head from the latched request, bodies/tail from the FIFO.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        ovalid       = 1'b0;
        odata        = '0;
        ovch         = '0;
        head_payload = '0;
        head_payload[15:0] = {4'(MY_X), 4'(MY_Y), dst_x_q, dst_y_q};
        if (rst_) begin
            case (state)
                ST_HEAD: begin
                    ovalid = vc_rdy;
                    odata  = {T_HEAD, head_payload};
                    ovch   = vc_q;
                end
                ST_BODY: begin
                    ovalid = !fifo_empty && vc_rdy;
                    ovch   = vc_q;
                    if (!fifo_empty) begin
                        odata = {(fifo_head[DATA_W] ? T_TAIL : T_BODY), fifo_head[DATA_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
        if (push) begin
            mem[wr_ptr] <= {s_last, s_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Packet FSM: accept request, send head, then drain payload until the tail.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state   <= ST_IDLE;
            dst_x_q <= '0;
            dst_y_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        dst_x_q <= req_dst_x;
                        dst_y_q <= req_dst_y;
                        state   <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (ovalid) state <= ST_BODY;
                end
                ST_BODY: begin
                    if (pop && fifo_head[DATA_W]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NOC_INJECT_VC_RR_EN
    logic [VCHW-1:0] rr_ptr;

    // Per-packet VC choice: take the pointer on acceptance, then advance it.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            rr_ptr <= '0;
            vc_q   <= '0;
        end else if (req_fire) begin
            vc_q   <= rr_ptr;
            rr_ptr <= rr_ptr + 1'b1;
        end
    end
`else
    // All traffic rides VC 0, so the other ready bits are only sunk here.
    logic unused_ordy;
    assign vc_q        = '0;
    assign unused_ordy = ^ordy;
`endif

endmodule
